// File: rtl/hps_input_capture.sv
// FPGA->HPS key input path: 2-flop sync, per-bit debounce, sticky edge capture, level IRQ,
// 4-phase clear handshake. Define HPS_IN_BOTH_EDGES_EN to also capture releases.

module hps_input_capture_lane #(
  parameter int CW              = 20,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic state,
  output logic set_evt
);
  localparam logic          IDLE = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic          lvl;
  logic          flip;
  logic [CW-1:0] cnt;

  assign lvl  = (ACTIVE_LOW != 0) ? ~s2 : s2;
  assign flip = (lvl != state) && (cnt == TERM);

`ifdef HPS_IN_BOTH_EDGES_EN
  assign set_evt = flip;
`else
  assign set_evt = flip & lvl;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= IDLE;
      s2    <= IDLE;
      cnt   <= '0;
      state <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any sample matching the accepted state restarts the stability window.
      if (lvl == state) begin
        cnt <= '0;
      end else if (flip) begin
        state <= lvl;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module hps_input_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_raw,
  input  logic             clr_req,
  input  logic [WIDTH-1:0] clr_mask,
  output logic             clr_ack,
  output logic [WIDTH-1:0] key_state,
  output logic [WIDTH-1:0] key_capture,
  output logic             irq
);
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0] set_evt;
  logic [WIDTH-1:0] cap_next;
  logic             do_clr;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      hps_input_capture_lane #(
        .CW              (CW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_lane (
        .clock   (clock),
        .reset   (reset),
        .raw     (key_raw[i]),
        .state   (key_state[i]),
        .set_evt (set_evt[i])
      );
    end
  endgenerate

  // One clear per request: a held clr_req only clears on its first cycle.
  assign do_clr = clr_req & ~clr_ack;

  always_comb begin
    cap_next = key_capture;
    if (do_clr) cap_next = cap_next & ~clr_mask;
    cap_next = cap_next | set_evt;  // set after clear so a coincident event survives
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_capture <= '0;
      clr_ack     <= 1'b0;
      irq         <= 1'b0;
    end else begin
      key_capture <= cap_next;
      irq         <= |key_capture;
      if (do_clr)        clr_ack <= 1'b1;
      else if (!clr_req) clr_ack <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hps_input_capture.sv
// Directed bench for hps_input_capture (WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
module tb_hps_input_capture;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] key_raw;
  logic       clr_req;
  logic [3:0] clr_mask;
  logic       clr_ack;
  logic [3:0] key_state;
  logic [3:0] key_capture;
  logic       irq;

  int n_chk  = 0;
  int n_fail = 0;

  hps_input_capture #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .key_raw     (key_raw),
    .clr_req     (clr_req),
    .clr_mask    (clr_mask),
    .clr_ack     (clr_ack),
    .key_state   (key_state),
    .key_capture (key_capture),
    .irq         (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n active edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; key_raw = 4'hF; clr_req = 1'b0; clr_mask = 4'h0;
    tick(2);
    check("rst_state", key_state, 4'h0);
    check("rst_cap",   key_capture, 4'h0);
    check("rst_ack",   clr_ack, 1'b0);
    check("rst_irq",   irq, 1'b0);
    reset = 1'b0;
    tick(1);

    // 1: press key 0
    key_raw = 4'b1110;
    tick(5);
    check("t1_state_early", key_state, 4'h0);
    tick(1);
    check("t1_state", key_state, 4'b0001);
    check("t1_cap",   key_capture, 4'b0001);
    check("t1_irq_lag", irq, 1'b0);
    tick(1);
    check("t1_irq", irq, 1'b1);

    // 2: 3-cycle glitch on key 1 is rejected
    key_raw = 4'b1100;
    tick(3);
    key_raw = 4'b1110;
    tick(8);
    check("t2_state", key_state, 4'b0001);
    check("t2_cap",   key_capture, 4'b0001);

    // real press on key 1 to reach capture=0011
    key_raw = 4'b1100;
    tick(7);
    check("t3_pre_cap", key_capture, 4'b0011);

    // 3: held request clears exactly once
    clr_mask = 4'b0001; clr_req = 1'b1;
    tick(1);
    check("t3_cap", key_capture, 4'b0010);
    check("t3_ack", clr_ack, 1'b1);
    tick(4);
    check("t3_cap_hold", key_capture, 4'b0010);
    check("t3_ack_hold", clr_ack, 1'b1);
    clr_req = 1'b0;
    tick(1);
    check("t3_ack_drop", clr_ack, 1'b0);
    check("t3_irq", irq, 1'b1);

    // 4: key 2 rises on the same edge a clear of bit 2 is taken
    key_raw = 4'b1000;
    tick(5);
    clr_mask = 4'b0100; clr_req = 1'b1;
    tick(1);
    check("t4_state", key_state, 4'b0111);
    check("t4_cap",   key_capture, 4'b0110);
    check("t4_ack",   clr_ack, 1'b1);
    clr_req = 1'b0;
    tick(1);
    check("t4_ack_drop", clr_ack, 1'b0);

    // 5: reset mid-count on key 3; all held keys re-debounce afterwards
    key_raw = 4'b0000;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("t5_state", key_state, 4'h0);
    check("t5_cap",   key_capture, 4'h0);
    check("t5_ack",   clr_ack, 1'b0);
    check("t5_irq",   irq, 1'b0);
    reset = 1'b0;
    tick(5);
    check("t5_state_early", key_state, 4'h0);
    tick(1);
    check("t5_state_after", key_state, 4'hF);
    check("t5_cap_after",   key_capture, 4'hF);

    // 6: clear everything, then release key 0
    clr_mask = 4'hF; clr_req = 1'b1;
    tick(1);
    clr_req = 1'b0;
    tick(1);
    check("t6_cleared", key_capture, 4'h0);
    tick(1);
    check("t6_irq_low", irq, 1'b0);
    key_raw = 4'b0001;
    tick(6);
    check("t6_state", key_state, 4'b1110);
`ifdef HPS_IN_BOTH_EDGES_EN
    check("t6_cap_release", key_capture, 4'b0001);
    tick(1);
    check("t6_irq_release", irq, 1'b1);
`else
    check("t6_cap_release", key_capture, 4'b0000);
    tick(1);
    check("t6_irq_release", irq, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
